// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the challenge generator and the receive-side checker.
// The polynomial x^16+x^14+x^13+x^11+1 is defined here once, as taps 15/13/12/10.
package lfsr_pkg;

    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Tap bit positions of the Fibonacci feedback.
    localparam int TAP_0 = 15;
    localparam int TAP_1 = 13;
    localparam int TAP_2 = 12;
    localparam int TAP_3 = 10;

    // Checker FSM states.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_e;

    // One LFSR step: shift left, feedback into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
        logic fb;
        fb = x[TAP_0] ^ x[TAP_1] ^ x[TAP_2] ^ x[TAP_3];
        return {x[LFSR_W-2:0], fb};
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises to the incoming word stream,
// reports lock, per-word match/mismatch pulses and a saturating error count.
//
// Handshake: data_valid qualifies data_in for exactly the cycle it is high; there
// is no backpressure, every valid beat is consumed. Responses (match, mismatch,
// locked, err_count) appear one cycle after the valid beat.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_valid,
    input  logic [15:0]       data_in,
    input  logic              clear_err,
    output logic              locked,
    output logic              match,
    output logic              mismatch,
    output logic [ERR_W-1:0]  err_count,
    output lfsr_state_e       dbg_state
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(LOSS_COUNT + 1);

    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_COUNT - 1);

    lfsr_state_e        state, state_n;
    logic [15:0]        pred, pred_n;
    logic [GOOD_W-1:0]  good, good_n;
    logic [MISS_W-1:0]  miss, miss_n;
    logic [ERR_W-1:0]   err_n;
    logic               match_n, mismatch_n;
    logic               err_inc;
    logic               hit;

    assign hit       = (data_in == pred);
    assign locked    = (state == LOCKED);
    assign dbg_state = state;

    // Next-state, predictor, run counters and response pulses.
    always_comb begin
        state_n    = state;
        pred_n     = pred;
        good_n     = good;
        miss_n     = miss;
        match_n    = 1'b0;
        mismatch_n = 1'b0;
        err_inc    = 1'b0;
        if (data_valid) begin
            case (state)
                HUNT: begin
                    // All-zero is the LFSR lock-up state, never a valid seed.
                    if (data_in != 16'h0000) begin
                        pred_n  = lfsr_next(data_in);
                        good_n  = '0;
                        state_n = VERIFY;
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        match_n = 1'b1;
                        pred_n  = lfsr_next(pred);
                        if (good == GOOD_LAST) begin
                            state_n = LOCKED;
                            good_n  = '0;
                            miss_n  = '0;
                        end else begin
                            good_n = good + GOOD_W'(1);
                        end
                    end else begin
                        // Not yet locked: trust the newest word as a fresh seed.
                        mismatch_n = 1'b1;
                        good_n     = '0;
                        if (data_in != 16'h0000) begin
                            pred_n = lfsr_next(data_in);
                        end else begin
                            state_n = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel on our own prediction so one corrupt word cannot derail it.
                    pred_n = lfsr_next(pred);
                    if (hit) begin
                        match_n = 1'b1;
                        miss_n  = '0;
                    end else begin
                        mismatch_n = 1'b1;
                        err_inc    = 1'b1;
                        if (miss == MISS_LAST) begin
                            state_n = HUNT;
                            miss_n  = '0;
                        end else begin
                            miss_n = miss + MISS_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = HUNT;
                end
            endcase
        end
    end

    // Error counter: clear wins over a same-cycle increment; saturates at all-ones.
    always_comb begin
        err_n = err_count;
        if (clear_err) begin
            err_n = '0;
        end else if (err_inc && !(&err_count)) begin
            err_n = err_count + ERR_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            pred      <= '0;
            good      <= '0;
            miss      <= '0;
            match     <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            pred      <= pred_n;
            good      <= good_n;
            miss      <= miss_n;
            match     <= match_n;
            mismatch  <= mismatch_n;
            err_count <= err_n;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed scenarios followed by a randomized stream,
// every beat compared against a behavioural model of the checker rules.
module tb_lfsr_checker;
    import lfsr_pkg::*;

    localparam int LOCK_N  = 4;
    localparam int LOSS_N  = 3;
    localparam int EW      = 4;
    localparam int ERR_MAX = (1 << EW) - 1;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           data_valid = 1'b0;
    logic [15:0]    data_in = '0;
    logic           clear_err = 1'b0;
    logic           locked, match, mismatch;
    logic [EW-1:0]  err_count;
    lfsr_state_e    dbg_state;

    always #5 clk = ~clk;

    lfsr_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .ERR_W(EW)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .data_in    (data_in),
        .clear_err  (clear_err),
        .locked     (locked),
        .match      (match),
        .mismatch   (mismatch),
        .err_count  (err_count),
        .dbg_state  (dbg_state)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // mode: 0 hunting, 1 verifying, 2 locked
    int          m_mode;
    logic [15:0] m_pred;
    int          m_good, m_miss, m_err;
    bit          m_match, m_mis;
    logic [15:0] g;   // last true sequence word sent

    function automatic logic [15:0] ref_next(input logic [15:0] x);
        int v, fb;
        v  = int'(x);
        fb = ((v >> 15) & 1) ^ ((v >> 13) & 1) ^ ((v >> 12) & 1) ^ ((v >> 10) & 1);
        return 16'(((v * 2) + fb) % 65536);
    endfunction

    function automatic lfsr_state_e mode_state(input int m);
        if (m == 2) return LOCKED;
        if (m == 1) return VERIFY;
        return HUNT;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pred = '0; m_good = 0; m_miss = 0; m_err = 0;
        m_match = 0; m_mis = 0;
    endtask

    task automatic model_step(input bit v, input logic [15:0] d, input bit clr);
        bit counted;
        counted = 0;
        m_match = 0;
        m_mis   = 0;
        if (v) begin
            if (m_mode == 0) begin
                if (d != 0) begin
                    m_pred = ref_next(d); m_good = 0; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (d == m_pred) begin
                    m_match = 1;
                    m_pred  = ref_next(m_pred);
                    m_good  = m_good + 1;
                    if (m_good == LOCK_N) begin m_mode = 2; m_miss = 0; end
                end else begin
                    m_mis  = 1;
                    m_good = 0;
                    if (d != 0) m_pred = ref_next(d);
                    else        m_mode = 0;
                end
            end else begin
                m_match = (d == m_pred);
                m_mis   = !m_match;
                m_pred  = ref_next(m_pred);
                if (m_mis) begin
                    counted = 1;
                    m_miss  = m_miss + 1;
                    if (m_miss == LOSS_N) begin m_mode = 0; m_miss = 0; end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (clr)                         m_err = 0;
        else if (counted && m_err < ERR_MAX) m_err = m_err + 1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".locked"},   32'(locked),    32'(m_mode == 2));
        chk({tag, ".match"},    32'(match),     32'(m_match));
        chk({tag, ".mismatch"}, 32'(mismatch),  32'(m_mis));
        chk({tag, ".err"},      32'(err_count), 32'(m_err));
        chk({tag, ".state"},    32'(dbg_state), 32'(mode_state(m_mode)));
    endtask

    // ---------------- driver tasks ----------------
    task automatic beat(input string tag, input bit v, input logic [15:0] d, input bit clr);
        @(negedge clk);
        data_valid = v;
        data_in    = d;
        clear_err  = clr;
        model_step(v, d, clr);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; data_valid = 1'b0; data_in = '0; clear_err = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_true(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            beat(tag, 1'b1, g, 1'b0);
            g = ref_next(g);
        end
    endtask

    task automatic send_bad(input string tag, input int n, input bit clr);
        for (int i = 0; i < n; i++) begin
            beat(tag, 1'b1, 16'hFFFF, clr);
            g = ref_next(g);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        g = 16'hACE1;
        do_reset("reset");

        // 1: seed plus four successors reaches lock
        send_true("t1", 5);
        chk("t1_locked", 32'(locked), 32'd1);
        chk("t1_second_word", 32'(ref_next(16'hACE1)), 32'h59C3);

        // 2: single corrupt word while locked
        send_bad("t2_bad", 1, 1'b0);
        chk("t2_err", 32'(err_count), 32'd1);
        chk("t2_locked", 32'(locked), 32'd1);
        send_true("t2_resume", 3);

        // 3: three consecutive bad words lose lock, then re-sync
        beat("t3_clear", 1'b0, 16'h0000, 1'b1);
        send_bad("t3_bad", 3, 1'b0);
        chk("t3_err", 32'(err_count), 32'd3);
        chk("t3_unlocked", 32'(locked), 32'd0);
        send_true("t3_resync", 5);
        chk("t3_relocked", 32'(locked), 32'd1);

        // 4: zero words are ignored in HUNT
        do_reset("t4_reset");
        for (int i = 0; i < 4; i++) beat("t4_zero", 1'b1, 16'h0000, 1'b0);
        chk("t4_hunt", 32'(dbg_state), 32'(HUNT));
        g = 16'hACE1;
        send_true("t4_seed", 1);
        chk("t4_verify", 32'(dbg_state), 32'(VERIFY));

        // 5: idle gaps between sequence words change nothing
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 10; j++) beat("t5_gap", 1'b0, 16'(j * 4099), 1'b0);
            send_true("t5_word", 1);
        end
        chk("t5_locked", 32'(locked), 32'd1);

        // 6: saturation, clear priority, reset while locked
        beat("t6_clear", 1'b0, 16'h0000, 1'b1);
        for (int r = 0; r < 5; r++) begin
            send_bad("t6_bad", 3, 1'b0);
            send_true("t6_relock", 5);
        end
        chk("t6_full", 32'(err_count), 32'(ERR_MAX));
        send_bad("t6_sat", 1, 1'b0);
        chk("t6_sat_hold", 32'(err_count), 32'(ERR_MAX));
        send_bad("t6_clr_mis", 1, 1'b1);
        chk("t6_clear_wins", 32'(err_count), 32'd0);
        send_true("t6_good", 1);
        do_reset("t6_rst");
        chk("t6_rst_unlocked", 32'(locked), 32'd0);

        // random stream: mostly true words with corruption, zeros, gaps and clears
        g = 16'(($urandom_range(1, 65535)));
        for (int i = 0; i < 600; i++) begin
            bit          v, c;
            int          r;
            logic [15:0] d;
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 24) == 0);
            r = $urandom_range(0, 11);
            if (r == 0)      d = 16'h0000;
            else if (r == 1) d = 16'($urandom);
            else             d = g;
            if (i == 300) do_reset("rnd_rst");
            beat("rnd", v, d, c);
            if (v) g = ref_next(g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
